// File: rtl/hex_bcd_display.sv
// hex_bcd_display: 32-cycle double-dabble converter showing a 32-bit word on eight active-low 7-seg digits.
// Define HEX_BCD_BLANK_EN to blank leading zeros on hex1..hex7.
module hex_bcd_display (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] value,
   input  logic        load,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5,
   output logic [6:0]  hex6,
   output logic [6:0]  hex7
);
   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
`ifdef HEX_BCD_BLANK_EN
   localparam logic [6:0] RST_HI = 7'h7f;
`else
   localparam logic [6:0] RST_HI = 7'h40;
`endif
   state_t      state;
   logic [31:0] sh;
   logic [31:0] pend_val;
   logic        pend_v;
   logic [39:0] bcd;
   logic [39:0] adj;
   logic [4:0]  cnt;
   logic [6:0]  disp  [8];
   logic [6:0]  seg_n [8];

   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = 7'h7f;
      endcase
   endfunction

   assign busy = state != IDLE;
   assign {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0} =
          {disp[7], disp[6], disp[5], disp[4], disp[3], disp[2], disp[1], disp[0]};

   always_comb begin
      adj = bcd;
      for (int i = 0; i < 10; i++)
         adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
   end

   for (genvar i = 0; i < 8; i++) begin : g_seg
`ifdef HEX_BCD_BLANK_EN
      if (i == 0) begin : g_lsd
         assign seg_n[i] = seg(bcd[3:0]);
      end else begin : g_blank
         assign seg_n[i] = bcd[31:4*i] == '0 ? 7'h7f : seg(bcd[4*i+:4]);
      end
`else
      assign seg_n[i] = seg(bcd[4*i+:4]);
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         sh       <= '0;
         bcd      <= '0;
         cnt      <= '0;
         pend_v   <= 1'b0;
         pend_val <= '0;
         done     <= 1'b0;
         overflow <= 1'b0;
         disp[0]  <= 7'h40;
         for (int i = 1; i < 8; i++) disp[i] <= RST_HI;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (load || pend_v) begin
               sh     <= load ? value : pend_val;
               pend_v <= 1'b0;
               bcd    <= '0;
               cnt    <= '0;
               state  <= SHIFT;
            end
            SHIFT: begin
               {bcd, sh} <= {adj, sh} << 1;
               cnt       <= cnt + 5'd1;
               if (cnt == 5'd31) state <= LATCH;
            end
            default: begin
               for (int i = 0; i < 8; i++) disp[i] <= seg_n[i];
               overflow <= bcd[39:32] != 8'd0;
               done     <= 1'b1;
               state    <= IDLE;
            end
         endcase
         // a load arriving mid-conversion parks in the one-deep slot, newest wins
         if (busy && load) begin
            pend_val <= value;
            pend_v   <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_hex_bcd_display.sv
// tb_hex_bcd_display: table-driven conversions plus pending-slot and mid-conversion reset sequences.
module tb_hex_bcd_display;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [31:0] value = '0;
   logic load = 1'b0;
   logic busy, done, overflow;
   logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
   int checks = 0;
   int errors = 0;

   hex_bcd_display dut (
      .clk(clk), .rst_n(rst_n), .value(value), .load(load),
      .busy(busy), .done(done), .overflow(overflow),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
      .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7)
   );

   always #5 clk = ~clk;

`ifdef HEX_BCD_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif
   localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f};

   typedef struct {
      logic [31:0] v;
      logic [31:0] dig;
      logic        ov;
   } vec_t;

   function automatic logic [55:0] img(input logic [31:0] d);
      logic [55:0] r;
      logic z;
      logic [3:0] n;
      r = '0;
      z = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         n = d[4*i+:4];
         z = z && (n == 4'd0);
         r[7*i+:7] = (BLANK && z && i > 0) ? 7'h7f : SEG[n];
      end
      return r;
   endfunction

   function automatic logic [55:0] disp();
      return {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run(input logic [31:0] v, output int lat, output int bcnt);
      @(negedge clk);
      value = v;
      load  = 1'b1;
      @(negedge clk);
      load = 1'b0;
      lat  = -1;
      bcnt = int'(busy);
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(negedge clk);
         bcnt += int'(busy);
         if (done) lat = k;
      end
   endtask

   initial begin
      vec_t tbl [7];
      int lat, bcnt, nd, t1, t2;
      logic [55:0] d1, d2;
      tbl[0] = '{32'd0,          32'h00000000, 1'b0};
      tbl[1] = '{32'd12345678,   32'h12345678, 1'b0};
      tbl[2] = '{32'hFFFFFFFF,   32'h94967295, 1'b1};
      tbl[3] = '{32'd1000,       32'h00001000, 1'b0};
      tbl[4] = '{32'd99999999,   32'h99999999, 1'b0};
      tbl[5] = '{32'd100000000,  32'h00000000, 1'b1};
      tbl[6] = '{32'd7,          32'h00000007, 1'b0};

      repeat (2) @(negedge clk);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset overflow", 64'(overflow), 64'd0);
      chk("reset image", 64'(disp()), 64'(img(32'h0)));
      rst_n = 1'b1;

      for (int t = 0; t < 7; t++) begin
         run(tbl[t].v, lat, bcnt);
         chk($sformatf("latency v=%0d", tbl[t].v), 64'(lat), 64'd33);
         chk($sformatf("busy cycles v=%0d", tbl[t].v), 64'(bcnt), 64'd33);
         chk($sformatf("hex v=%0d", tbl[t].v), 64'(disp()), 64'(img(tbl[t].dig)));
         chk($sformatf("overflow v=%0d", tbl[t].v), 64'(overflow), 64'(tbl[t].ov));
         @(negedge clk);
         chk($sformatf("done width v=%0d", tbl[t].v), 64'(done), 64'd0);
         chk($sformatf("hold v=%0d", tbl[t].v), 64'(disp()), 64'(img(tbl[t].dig)));
      end

      // loads at cycles 0, 5, 10: 42 is superseded by 99 in the pending slot
      nd = 0; t1 = -1; t2 = -1; d1 = '0; d2 = '0;
      for (int c = 0; c <= 80; c++) begin
         load  = (c == 0 || c == 5 || c == 10);
         value = c == 0 ? 32'd7 : c == 5 ? 32'd42 : 32'd99;
         @(negedge clk);
         if (done) begin
            if (nd == 0) begin t1 = c; d1 = disp(); end
            else if (nd == 1) begin t2 = c; d2 = disp(); end
            nd++;
         end
      end
      load = 1'b0;
      chk("pending done count", 64'(nd), 64'd2);
      chk("pending first time", 64'(t1), 64'd33);
      chk("pending first image", 64'(d1), 64'(img(32'h7)));
      chk("pending second time", 64'(t2), 64'd67);
      chk("pending second image", 64'(d2), 64'(img(32'h99)));

      // reset at cycle 15 with a value parked in the pending slot
      for (int c = 0; c < 15; c++) begin
         load  = (c == 0 || c == 10);
         value = c == 0 ? 32'd12345678 : 32'd5;
         @(negedge clk);
      end
      load  = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort image", 64'(disp()), 64'(img(32'h0)));
      chk("abort overflow", 64'(overflow), 64'd0);
      rst_n = 1'b1;
      nd = 0;
      bcnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         nd += int'(done);
         bcnt += int'(busy);
      end
      chk("abort no done", 64'(nd), 64'd0);
      chk("abort pending empty", 64'(bcnt), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hex_bcd_display.md
# hex_bcd_display

Consumer of the CPU's 32-bit GPIO output register: takes the value the CPU writes to its output port and shows it in decimal on eight active-low seven-segment digits. A sequential double-dabble converter turns the binary word into ten BCD digits over 32 cycles. The low eight digits drive the displays; values above 99,999,999 raise an overflow flag. Sits between the CPU output register and the board's HEX0–HEX7 pins, in the same clock domain as the CPU.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  system clock, same clock as the CPU
- rst_n  input  1  reset; synchronous, active-low
- value  input  32  unsigned binary word, connected to the CPU output register
- load  input  1  one-cycle strobe: "value is new"; driven high the cycle after the CPU's output write enable
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when the display outputs update
- overflow  output  1  high when the last converted value exceeds 99,999,999
- hex0..hex7  output  7 each  active-low segments, bit order {g,f,e,d,c,b,a}; hex0 is the least-significant digit

## Operation
- States: IDLE, SHIFT, LATCH.
- Registers:
  - sh[31:0]: shift source
  - bcd[39:0]: ten BCD digits
  - cnt[4:0]: shift counter
  - pend_val[31:0] and pend_v: one-deep pending slot
- **IDLE:**
  - If load=1: sh←value, bcd←0, cnt←0, go to SHIFT.
  - Else if pend_v=1: sh←pend_val, pend_v←0, bcd←0, cnt←0, go to SHIFT.
  - load has priority over pend_v; when load wins, pend_v is cleared, because the newer value supersedes the pending one.
- **SHIFT:** each cycle
  - For every BCD digit ≥5, add 3 to that digit (all digits evaluated in parallel on the pre-shift bcd).
  - Shift {bcd,sh} left by 1.
  - cnt←cnt+1.
  - After the shift with cnt==31, go to LATCH.
- **LATCH:**
  - hexN←seg(bcd digit N) for N=0..7.
  - overflow←(bcd[39:32]!=0).
  - done←1.
  - Go to IDLE.
- **load while busy:** pend_val←value, pend_v←1. The newest value wins; older pending values are lost.
- **Segment map (active-low gfedcba):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
  - Digits >9 cannot occur.
- **Reset (synchronous, rst_n=0 at a clk edge):**
  - State←IDLE; sh, bcd, cnt, pend_v←0.
  - busy=0, done=0, overflow=0.
  - hex0..hex7 take the display image of value 0 (see Configuration).
  - Reset mid-conversion aborts the conversion with no done pulse and discards any pending value.

## Timing
- E0 is the edge where load is sampled in IDLE.
- Shifts occur on E1..E32; LATCH executes on E33.
- busy is high from after E0 until after E33; it is combinational from state != IDLE.
- hex0..hex7, overflow and done are registered and change only at E33. done is high for exactly the cycle between E33 and E34.
- Display latency: 33 cycles from the load edge to new segments.
- The pending slot starts its conversion at E34, so a back-to-back pending value completes at E67.
- Between conversions, hex and overflow outputs hold their last values.

## Configuration
- Macro: HEX_BCD_BLANK_EN.
- **Defined:** leading-zero blanking.
  - hexN shows blank if digits N..7 are all zero, for N=1..7.
  - hex0 always shows its digit.
  - Reset image: hex0=1000000, hex1..hex7=1111111.
- **Undefined:** all eight digits always show their value, including leading zeros. Reset image: all hexN=1000000.

## Test plan
- Reset, then value=0 with load pulse → after 33 cycles done=1 for 1 cycle, overflow=0, hex0=1000000; hex1..7=1000000 (macro off) or 1111111 (macro on).
- value=12345678, load → hex7..hex0 = 1,2,3,4,5,6,7,8 segment codes (hex0=0000000, hex7=1111001), overflow=0, busy high for exactly 33 cycles.
- value=32'hFFFFFFFF (4294967295), load → overflow=1, hex7..hex0 show 9,4,9,6,7,2,9,5.
- Loads at cycles 0, 5 and 10 (values 7, 42, 99) → first done at cycle 33 showing 7, second done at cycle 67 showing 99; 42 is never displayed.
- Load 12345678, rst_n=0 at cycle 15 → no done pulse, busy=0 after the reset edge, hex outputs at the reset image, pending slot empty.
- Macro on, value=1000 → hex3..hex0 = 1,0,0,0 codes, hex4..hex7 = 1111111.
